// File: rtl/gpio_bank.sv
// GPIO bank: registered pad control, 2-flop input synchroniser, per-channel
// debounce filter and sticky edge-interrupt status.

module gpio_lane #(
    parameter int DB_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_i,
    input  logic            dir_i,
    input  logic            pad_in_i,
    input  logic [DB_W-1:0] db_limit_i,
    input  logic [1:0]      edge_sel_i,
    input  logic            clr_i,
    output logic            y_o,
    output logic            status_o,
    output logic            pad_out_o,
    output logic            pad_oe_n_o,
    output logic            pad_inp_dis_o,
    output logic [2:0]      pad_dm_o
);
    logic            dir_q, dir_d;
    logic            pad_out_q, pad_out_d;
    logic [1:0]      sync_q, sync_d;
    logic            f_q, f_d;
    logic            fp_q, fp_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic [1:0]      ign_q, ign_d;
    logic            st_q, st_d;
    logic            s, rise, fall, set;

    assign s    = sync_q[1];
    assign rise = f_q & ~fp_q;
    assign fall = ~f_q & fp_q;
    assign set  = ~dir_q & ((rise & edge_sel_i[0]) | (fall & edge_sel_i[1]));

    always_comb begin
        dir_d     = dir_i;
        pad_out_d = dir_i & a_i;
        sync_d    = sync_q;
        f_d       = f_q;
        fp_d      = f_q;
        cnt_d     = cnt_q;
        ign_d     = ign_q;
        st_d      = set | (st_q & ~clr_i);
        if (dir_q) begin
            cnt_d = '0;
            ign_d = 2'd2;
        end else begin
            sync_d = {sync_q[0], pad_in_i};
            // Just turned around to input: let the synchroniser refill first.
            if (ign_q != 2'd0) begin
                ign_d = ign_q - 2'd1;
                cnt_d = '0;
            end else if (s == f_q) begin
                cnt_d = '0;
            end else if (cnt_q >= db_limit_i) begin
                f_d   = s;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q     <= 1'b0;
            pad_out_q <= 1'b0;
            sync_q    <= '0;
            f_q       <= 1'b0;
            fp_q      <= 1'b0;
            cnt_q     <= '0;
            ign_q     <= '0;
            st_q      <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            pad_out_q <= pad_out_d;
            sync_q    <= sync_d;
            f_q       <= f_d;
            fp_q      <= fp_d;
            cnt_q     <= cnt_d;
            ign_q     <= ign_d;
            st_q      <= st_d;
        end
    end

    assign y_o           = f_q;
    assign status_o      = st_q;
    assign pad_out_o     = pad_out_q;
    assign pad_oe_n_o    = ~dir_q;
    assign pad_inp_dis_o = dir_q;
    assign pad_dm_o      = {dir_q, 2'b10};
endmodule

module gpio_bank #(
    parameter int WIDTH = 8,
    parameter int DB_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     Y,
    input  logic [WIDTH-1:0]     DIR,
    input  logic [DB_W-1:0]      DB_LIMIT,
    input  logic [2*WIDTH-1:0]   IRQ_EDGE,
    input  logic [WIDTH-1:0]     IRQ_CLR,
    output logic [WIDTH-1:0]     IRQ_STATUS,
    output logic                 IRQ,
    output logic [WIDTH-1:0]     pad_out,
    output logic [WIDTH-1:0]     pad_oe_n,
    output logic [WIDTH-1:0]     pad_inp_dis,
    output logic [3*WIDTH-1:0]   pad_dm,
    input  logic [WIDTH-1:0]     pad_in
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        gpio_lane #(.DB_W(DB_W)) u_lane (
            .clk          (clk),
            .rst          (rst),
            .a_i          (A[i]),
            .dir_i        (DIR[i]),
            .pad_in_i     (pad_in[i]),
            .db_limit_i   (DB_LIMIT),
            .edge_sel_i   (IRQ_EDGE[2*i +: 2]),
            .clr_i        (IRQ_CLR[i]),
            .y_o          (Y[i]),
            .status_o     (IRQ_STATUS[i]),
            .pad_out_o    (pad_out[i]),
            .pad_oe_n_o   (pad_oe_n[i]),
            .pad_inp_dis_o(pad_inp_dis[i]),
            .pad_dm_o     (pad_dm[3*i +: 3])
        );
    end

    assign IRQ = |IRQ_STATUS;
endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: reference model predicts every cycle into a queue,
// a negedge monitor pops and compares; directed scenarios plus random traffic.

module tb_gpio_bank;
    localparam int W   = 8;
    localparam int DBW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [W-1:0]     A, DIR, IRQ_CLR, pad_in;
    logic [DBW-1:0]   DB_LIMIT;
    logic [2*W-1:0]   IRQ_EDGE;
    logic [W-1:0]     Y, IRQ_STATUS, pad_out, pad_oe_n, pad_inp_dis;
    logic             IRQ;
    logic [3*W-1:0]   pad_dm;

    gpio_bank #(.WIDTH(W), .DB_W(DBW)) dut (
        .clk(clk), .rst(rst), .A(A), .Y(Y), .DIR(DIR), .DB_LIMIT(DB_LIMIT),
        .IRQ_EDGE(IRQ_EDGE), .IRQ_CLR(IRQ_CLR), .IRQ_STATUS(IRQ_STATUS), .IRQ(IRQ),
        .pad_out(pad_out), .pad_oe_n(pad_oe_n), .pad_inp_dis(pad_inp_dis),
        .pad_dm(pad_dm), .pad_in(pad_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]   y, st;
        logic           irq;
        logic [W-1:0]   po, oen, idis;
        logic [3*W-1:0] dm;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Model state: pad-side sample pipeline, filtered level, previous level,
    // consecutive-mismatch run length, turnaround holdoff, direction, status.
    bit m_s1[W], m_s2[W], m_f[W], m_fp[W], m_dir[W], m_po[W], m_st[W];
    int m_run[W], m_ign[W];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e = '0;
        for (int i = 0; i < W; i++) begin
            e.y[i]          = m_f[i];
            e.st[i]         = m_st[i];
            e.po[i]         = m_po[i];
            e.oen[i]        = ~m_dir[i];
            e.idis[i]       = m_dir[i];
            e.dm[3*i +: 3]  = m_dir[i] ? 3'b110 : 3'b010;
        end
        e.irq = |e.st;
        return e;
    endfunction

    task automatic model_step();
        for (int i = 0; i < W; i++) begin
            bit s, f, rise, fall, set;
            logic [1:0] es;
            if (rst) begin
                m_s1[i] = 0; m_s2[i] = 0; m_f[i] = 0; m_fp[i] = 0;
                m_dir[i] = 0; m_po[i] = 0; m_st[i] = 0; m_run[i] = 0; m_ign[i] = 0;
            end else begin
                s = m_s2[i]; f = m_f[i];
                es = IRQ_EDGE[2*i +: 2];
                rise = f & ~m_fp[i];
                fall = ~f & m_fp[i];
                set = !m_dir[i] && ((rise && es[0]) || (fall && es[1]));
                m_fp[i] = f;
                if (m_dir[i]) begin
                    m_run[i] = 0;
                    m_ign[i] = 2;
                end else begin
                    // Level flips on the (DB_LIMIT+1)-th consecutive cycle of disagreement.
                    if (m_ign[i] > 0) begin
                        m_ign[i]--; m_run[i] = 0;
                    end else if (s == f) m_run[i] = 0;
                    else if (m_run[i] >= int'(DB_LIMIT)) begin
                        m_f[i] = s; m_run[i] = 0;
                    end else m_run[i]++;
                    m_s2[i] = m_s1[i];
                    m_s1[i] = pad_in[i];
                end
                m_st[i]  = set ? 1'b1 : (IRQ_CLR[i] ? 1'b0 : m_st[i]);
                m_dir[i] = DIR[i];
                m_po[i]  = DIR[i] & A[i];
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        q.push_back(snap());
        #1;
    endtask

    task automatic cycn(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic check_reset_vals(input string tag);
        cmp({tag, "_Y"}, Y, '0);
        cmp({tag, "_ST"}, IRQ_STATUS, '0);
        cmp({tag, "_IRQ"}, IRQ, 1'b0);
        cmp({tag, "_PO"}, pad_out, '0);
        cmp({tag, "_OEN"}, pad_oe_n, {W{1'b1}});
        cmp({tag, "_IDIS"}, pad_inp_dis, '0);
        cmp({tag, "_DM"}, pad_dm, {W{3'b010}});
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("sb_Y", Y, e.y);
            cmp("sb_STATUS", IRQ_STATUS, e.st);
            cmp("sb_IRQ", IRQ, e.irq);
            cmp("sb_PAD_OUT", pad_out, e.po);
            cmp("sb_PAD_OE_N", pad_oe_n, e.oen);
            cmp("sb_PAD_INP_DIS", pad_inp_dis, e.idis);
            cmp("sb_PAD_DM", pad_dm, e.dm);
        end
    end

    initial begin
        rst = 1'b1; A = '0; DIR = '0; IRQ_CLR = '0; pad_in = '0;
        DB_LIMIT = '0; IRQ_EDGE = '0;
        #1;
        check_reset_vals("rst0");
        cycn(3);
        rst = 1'b0;
        cycn(3);

        // Bypass debounce: Y at t+3, status/IRQ at t+4.
        IRQ_EDGE[1:0] = 2'b01;
        pad_in[0] = 1'b1;
        cycn(2);
        cmp("dl0_Y_t2", Y[0], 1'b0);
        cyc();
        cmp("dl0_Y_t3", Y[0], 1'b1);
        cmp("dl0_ST_t3", IRQ_STATUS[0], 1'b0);
        cyc();
        cmp("dl0_ST_t4", IRQ_STATUS[0], 1'b1);
        cmp("dl0_IRQ_t4", IRQ, 1'b1);
        cycn(2);

        // Debounce of 4: 3-cycle glitch rejected, held level appears at t+7.
        DB_LIMIT = 4'd4;
        IRQ_EDGE[3:2] = 2'b11;
        pad_in[1] = 1'b1;
        cycn(3);
        pad_in[1] = 1'b0;
        cycn(10);
        cmp("glitch_Y", Y[1], 1'b0);
        cmp("glitch_ST", IRQ_STATUS[1], 1'b0);
        pad_in[1] = 1'b1;
        cycn(6);
        cmp("db4_Y_t6", Y[1], 1'b0);
        cyc();
        cmp("db4_Y_t7", Y[1], 1'b1);
        cycn(3);

        // Output mode on ch2: pad controls next cycle, input path frozen.
        DIR[2] = 1'b1; A[2] = 1'b1;
        cyc();
        cmp("out_OEN", pad_oe_n[2], 1'b0);
        cmp("out_IDIS", pad_inp_dis[2], 1'b1);
        cmp("out_DM", pad_dm[8:6], 3'b110);
        cmp("out_PO", pad_out[2], 1'b1);
        IRQ_EDGE[5:4] = 2'b11;
        for (int k = 0; k < 12; k++) begin
            pad_in[2] = ~pad_in[2];
            cyc();
            cmp("out_Y_frozen", Y[2], 1'b0);
        end
        pad_in[2] = 1'b0;
        DIR[2] = 1'b0;
        cycn(12);

        // Simultaneous set and clear keeps the bit; clear alone drops it.
        DB_LIMIT = 4'd0;
        IRQ_CLR = '1;
        cyc();
        IRQ_CLR = '0;
        IRQ_EDGE[7:6] = 2'b11;
        pad_in[3] = 1'b1;
        cycn(6);
        cmp("ch3_rise_ST", IRQ_STATUS[3], 1'b1);
        pad_in[3] = 1'b0;
        cycn(3);
        IRQ_CLR[3] = 1'b1;
        cyc();
        cmp("ch3_setclr_ST", IRQ_STATUS[3], 1'b1);
        cyc();
        cmp("ch3_clr_ST", IRQ_STATUS[3], 1'b0);
        cmp("ch3_clr_IRQ", IRQ, 1'b0);
        IRQ_CLR = '0;
        cycn(2);

        // Reset mid-debounce on ch4 with another channel in output mode.
        DB_LIMIT = 4'd4;
        DIR[5] = 1'b1; A = '1;
        IRQ_EDGE[9:8] = 2'b11;
        cycn(2);
        pad_in[4] = 1'b1;
        cycn(4);
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        q.delete();
        cycn(2);
        DIR[5] = 1'b0;
        rst = 1'b0;
        cycn(6);
        cmp("rst_Y4_t6", Y[4], 1'b0);
        cmp("rst_noedge_ST", IRQ_STATUS, '0);
        cyc();
        cmp("rst_Y4_t7", Y[4], 1'b1);
        cycn(3);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            A = W'($urandom);
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 5) == 0)  pad_in[i] = ~pad_in[i];
                if ($urandom_range(0, 60) == 0) DIR[i] = ~DIR[i];
            end
            IRQ_CLR = W'($urandom) & W'($urandom) & W'($urandom);
            if ($urandom_range(0, 80) == 0) IRQ_EDGE = 16'($urandom);
            if ($urandom_range(0, 100) == 0) DB_LIMIT = DBW'($urandom_range(0, 5));
            cyc();
        end

        IRQ_CLR = '0;
        cycn(2);
        @(negedge clk);
        #1;
        cmp("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
